// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way
// round-robin burst arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority pick: first request at or
// after ptr, ascending modulo 4.
module arb_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  // fixed-priority pick on the rotated vector
  always_comb begin
    off = '0;
    priority case (1'b1)
      rot[0]: off = 2'd0;
      rot[1]: off = 2'd1;
      rot[2]: off = 2'd2;
      rot[3]: off = 2'd3;
      default: off = '0;
    endcase
  end

  assign found = |req;
  assign idx   = off + ptr;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving a 4:1 mux
// onto one downstream valid/ready channel.
module mux_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  input  logic [N_REQ-1:0]        in_last,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [1:0]              sel,
  output logic                    busy,
  output logic [7:0]              beat_cnt
);

  import mux_arb_pkg::*;

  arb_state_t       state;
  arb_state_t       state_nx;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic [SEL_W-1:0] win;
  logic             hs;
  logic             hs_last;

  arb_rr_pick u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .found (found),
    .idx   (win)
  );

  assign busy     = (state == BUSY);
  assign grant    = grant_q;
  assign sel      = sel_q;
  assign beat_cnt = cnt;

  // data mux and ready steering for the owner
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (busy) begin
      out_valid       = in_valid[sel_q];
      out_data        =
        in_data[int'(sel_q)*DATA_W +: DATA_W];
      out_last        = in_last[sel_q];
      in_ready[sel_q] = out_ready;
    end
  end

  assign hs      = out_valid & out_ready;
  assign hs_last = hs & out_last;

  // next state: claim on any request, free on last
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (found)   state_nx = BUSY;
      BUSY: if (hs_last) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // grant, select, pointer and beat counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q <= '0;
      sel_q   <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_q <= onehot(win);
            sel_q   <= win;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (hs_last) begin
            grant_q <= '0;
            ptr     <= sel_q + 1'b1;
            cnt     <= '0;
          end else if (hs && cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_grant_1hot: assert property (
    @(posedge clk) disable iff (!rstn)
    $onehot0(grant_q));

  a_grant_busy: assert property (
    @(posedge clk) disable iff (!rstn)
    (grant_q != '0) == busy);

  a_sel_idx: assert property (
    @(posedge clk) disable iff (!rstn)
    busy |-> grant_q == onehot(sel_q));

  a_ready_1: assert property (
    @(posedge clk) disable iff (!rstn)
    $countones(in_ready) <= 1);

endmodule
